// File: rtl/mem_wb_stage.sv
// mem_wb_stage: rv32i memory-access and writeback stage.
// Performs the data-memory load/store for the M stage. Registers the result
// into the W pipeline register and drives the register-file write port.
// Also keeps a sticky access-error flag and saturating load/store counters.

package rv32i_pkg;
  localparam int DPW = 32;
endpackage

module mem_wb_stage #(
  parameter int DPW = rv32i_pkg::DPW,
  parameter int ADW = 5,
  parameter int DMW = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  // M-stage register outputs
  input  logic           regwriteM,
  input  logic           resultsrcM,
  input  logic           memwriteM,
  input  logic [DPW-1:0] aluresultM,
  input  logic [DPW-1:0] Rd2M,
  input  logic [ADW-1:0] RdM,
  // register-file write port
  output logic           regwriteW,
  output logic [ADW-1:0] RdW,
  output logic [DPW-1:0] resultW,
  // debug
  output logic           mem_err,
  output logic [15:0]    load_cnt,
  output logic [15:0]    store_cnt
);

  localparam int          DEPTH   = 2 ** DMW;
  localparam logic [15:0] CNT_MAX = 16'hFFFF;

  // ---------------------------------------------------------------------------
  // Address decode and access classification
  // ---------------------------------------------------------------------------
  logic [DMW-1:0] idx;
  logic           aligned;
  logic           in_range;
  logic           acc_ok;
  logic           is_store;
  logic           is_load;
  logic           store_ok;
  logic           load_ok;
  logic           acc_bad;

  // A cycle with both load and store requested is treated as a store only.
  always_comb begin
    idx      = aluresultM[DMW+1:2];
    aligned  = (aluresultM[1:0] == 2'b00);
    in_range = (aluresultM[DPW-1:DMW+2] == '0);
    acc_ok   = aligned & in_range;
    is_store = memwriteM;
    is_load  = resultsrcM & ~memwriteM;
    store_ok = is_store & acc_ok;
    load_ok  = is_load & acc_ok;
    acc_bad  = (is_store | is_load) & ~acc_ok;
  end

  // ---------------------------------------------------------------------------
  // Data memory (not reset; combinational read, synchronous write)
  // ---------------------------------------------------------------------------
  logic [DPW-1:0] mem [DEPTH];
  logic [DPW-1:0] readdataM;

  // Commit a valid store; a store seen while reset is held is dropped.
  always_ff @(posedge clk) begin
    if (rst_n && store_ok) begin
      mem[idx] <= Rd2M;
    end
  end

  // Invalid addresses read as zero so nothing out of range leaks to W.
  always_comb begin
    readdataM = '0;
    if (acc_ok) begin
      readdataM = mem[idx];
    end
  end

  // ---------------------------------------------------------------------------
  // W pipeline register
  // ---------------------------------------------------------------------------
  logic           regwrite_q,   regwrite_d;
  logic [ADW-1:0] rd_q,         rd_d;
  logic           resultsrc_q,  resultsrc_d;
  logic [DPW-1:0] aluresult_q,  aluresult_d;
  logic [DPW-1:0] readdata_q,   readdata_d;

  // Next W values; x0 is never written, and a store never selects load data.
  always_comb begin
    regwrite_d  = regwriteM & (RdM != '0);
    rd_d        = RdM;
    resultsrc_d = is_load;
    aluresult_d = aluresultM;
    readdata_d  = readdataM;
  end

  // W register state, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regwrite_q  <= 1'b0;
      rd_q        <= '0;
      resultsrc_q <= 1'b0;
      aluresult_q <= '0;
      readdata_q  <= '0;
    end else begin
      regwrite_q  <= regwrite_d;
      rd_q        <= rd_d;
      resultsrc_q <= resultsrc_d;
      aluresult_q <= aluresult_d;
      readdata_q  <= readdata_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Error flag and access counters
  // ---------------------------------------------------------------------------
  logic        mem_err_q,   mem_err_d;
  logic [15:0] load_cnt_q,  load_cnt_d;
  logic [15:0] store_cnt_q, store_cnt_d;

  // Sticky error; counters advance on valid accesses and hold at all-ones.
  always_comb begin
    mem_err_d   = mem_err_q | acc_bad;
    load_cnt_d  = load_cnt_q;
    store_cnt_d = store_cnt_q;
    if (load_ok && (load_cnt_q != CNT_MAX)) begin
      load_cnt_d = load_cnt_q + 16'd1;
    end
    if (store_ok && (store_cnt_q != CNT_MAX)) begin
      store_cnt_d = store_cnt_q + 16'd1;
    end
  end

  // Debug state, cleared asynchronously and updated alongside the W register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_err_q   <= 1'b0;
      load_cnt_q  <= '0;
      store_cnt_q <= '0;
    end else begin
      mem_err_q   <= mem_err_d;
      load_cnt_q  <= load_cnt_d;
      store_cnt_q <= store_cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  // Writeback mux is combinational from W so the result is stable all cycle.
  always_comb begin
    regwriteW = regwrite_q;
    RdW       = rd_q;
    resultW   = resultsrc_q ? readdata_q : aluresult_q;
    mem_err   = mem_err_q;
    load_cnt  = load_cnt_q;
    store_cnt = store_cnt_q;
  end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Testbench for mem_wb_stage: directed scenarios plus randomized traffic,
// checked against a word-level memory/pipeline model kept in the bench.

module tb_mem_wb_stage;

  logic        clk;
  logic        rst_n;
  logic        regwriteM;
  logic        resultsrcM;
  logic        memwriteM;
  logic [31:0] aluresultM;
  logic [31:0] Rd2M;
  logic [4:0]  RdM;
  logic        regwriteW;
  logic [4:0]  RdW;
  logic [31:0] resultW;
  logic        mem_err;
  logic [15:0] load_cnt;
  logic [15:0] store_cnt;

  mem_wb_stage dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .regwriteM  (regwriteM),
    .resultsrcM (resultsrcM),
    .memwriteM  (memwriteM),
    .aluresultM (aluresultM),
    .Rd2M       (Rd2M),
    .RdM        (RdM),
    .regwriteW  (regwriteW),
    .RdW        (RdW),
    .resultW    (resultW),
    .mem_err    (mem_err),
    .load_cnt   (load_cnt),
    .store_cnt  (store_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vec_cnt  = 0;
  int miscompares = 0;
  bit verbose  = 1'b1;

  // Reference model: 256-word memory with per-word "written" tracking,
  // plus the expected state of everything visible after each edge.
  logic [31:0] mdl_mem   [256];
  bit          mdl_known [256];
  bit          exp_rw;
  logic [4:0]  exp_rd;
  logic [31:0] exp_res;
  bit          exp_known;
  bit          exp_err;
  int          exp_lcnt;
  int          exp_scnt;

  task automatic model_reset();
    exp_rw    = 1'b0;
    exp_rd    = '0;
    exp_res   = '0;
    exp_known = 1'b1;
    exp_err   = 1'b0;
    exp_lcnt  = 0;
    exp_scnt  = 0;
  endtask

  // Drive one M-stage transaction, clock it, and advance the model.
  task automatic step(input bit rw, input bit rs, input bit mw,
                      input logic [31:0] alu, input logic [31:0] d,
                      input logic [4:0] rd);
    bit ok;
    bit is_ld;
    bit is_st;
    int w;
    regwriteM  = rw;
    resultsrcM = rs;
    memwriteM  = mw;
    aluresultM = alu;
    Rd2M       = d;
    RdM        = rd;
    ok    = (alu % 4 == 0) && (alu < 32'd1024);
    w     = int'(alu / 4) % 256;
    is_st = mw;
    is_ld = rs && !mw;
    exp_rw = rw && (rd != 5'd0);
    exp_rd = rd;
    if (is_ld) begin
      exp_res   = ok ? mdl_mem[w] : 32'd0;
      exp_known = !ok || mdl_known[w];
    end else begin
      exp_res   = alu;
      exp_known = 1'b1;
    end
    if ((is_st || is_ld) && !ok) exp_err = 1'b1;
    if (is_ld && ok && exp_lcnt < 65535) exp_lcnt++;
    if (is_st && ok && exp_scnt < 65535) exp_scnt++;
    @(posedge clk);
    #1;
    if (is_st && ok) begin
      mdl_mem[w]   = d;
      mdl_known[w] = 1'b1;
    end
    if (verbose)
      $display("txn rw=%0d ld=%0d st=%0d addr=%08h wd=%08h rd=%0d -> we=%0d RdW=%0d resultW=%08h err=%0d lc=%0d sc=%0d",
               rw, rs, mw, alu, d, rd, regwriteW, RdW, resultW, mem_err, load_cnt, store_cnt);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 6; i++) begin
      regwriteM  = 1'($urandom);
      resultsrcM = 1'($urandom);
      memwriteM  = 1'($urandom);
      aluresultM = {22'd0, 8'($urandom), 2'b00};
      Rd2M       = $urandom;
      RdM        = 5'($urandom);
      @(posedge clk);
      #1;
      vec_cnt++;
      if ({regwriteW, RdW, resultW, mem_err, load_cnt, store_cnt} !== '0) begin
        miscompares++;
        $display("FAIL reset_hold cyc=%0d got we=%0d rd=%0d res=%08h err=%0d lc=%0d sc=%0d expected all 0",
                 i, regwriteW, RdW, resultW, mem_err, load_cnt, store_cnt);
      end
    end
    model_reset();
    rst_n = 1'b1;
    step(1, 0, 0, 32'hCAFE0001, 32'h0, 5'd5);
    vec_cnt++;
    if (regwriteW !== 1'b1 || RdW !== 5'd5 || resultW !== 32'hCAFE0001) begin
      miscompares++;
      $display("FAIL reset_release got we=%0d rd=%0d res=%08h expected we=1 rd=5 res=cafe0001",
               regwriteW, RdW, resultW);
    end
    vec_cnt++;
    if (load_cnt !== 16'd0 || store_cnt !== 16'd0 || mem_err !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_release_dbg got err=%0d lc=%0d sc=%0d expected 0 0 0",
               mem_err, load_cnt, store_cnt);
    end
  endtask

  task automatic test_store_load();
    step(0, 0, 1, 32'h10, 32'hDEADBEEF, 5'd0);
    step(1, 1, 0, 32'h10, 32'h0, 5'd7);
    vec_cnt++;
    if (regwriteW !== 1'b1 || RdW !== 5'd7 || resultW !== 32'hDEADBEEF) begin
      miscompares++;
      $display("FAIL store_load got we=%0d rd=%0d res=%08h expected we=1 rd=7 res=deadbeef",
               regwriteW, RdW, resultW);
    end
    vec_cnt++;
    if (store_cnt !== 16'd1 || load_cnt !== 16'd1) begin
      miscompares++;
      $display("FAIL store_load_cnt got sc=%0d lc=%0d expected sc=1 lc=1", store_cnt, load_cnt);
    end
  endtask

  task automatic test_alu_writeback();
    step(1, 0, 0, 32'h12345678, 32'h0, 5'd3);
    vec_cnt++;
    if (regwriteW !== 1'b1 || RdW !== 5'd3 || resultW !== 32'h12345678) begin
      miscompares++;
      $display("FAIL alu_wb got we=%0d rd=%0d res=%08h expected we=1 rd=3 res=12345678",
               regwriteW, RdW, resultW);
    end
    step(1, 0, 0, 32'h12345678, 32'h0, 5'd0);
    vec_cnt++;
    if (regwriteW !== 1'b0 || RdW !== 5'd0) begin
      miscompares++;
      $display("FAIL alu_wb_x0 got we=%0d rd=%0d expected we=0 rd=0", regwriteW, RdW);
    end
    vec_cnt++;
    if (mem_err !== 1'b0) begin
      miscompares++;
      $display("FAIL alu_wb_err got err=%0d expected 0", mem_err);
    end
  endtask

  task automatic test_bad_access();
    step(0, 0, 1, 32'h13, 32'h11111111, 5'd0);
    vec_cnt++;
    if (mem_err !== 1'b1 || store_cnt !== 16'd1) begin
      miscompares++;
      $display("FAIL misaligned_store got err=%0d sc=%0d expected err=1 sc=1", mem_err, store_cnt);
    end
    step(0, 0, 1, 32'h400, 32'h22222222, 5'd0);
    step(1, 1, 0, 32'h10, 32'h0, 5'd7);
    vec_cnt++;
    if (resultW !== 32'hDEADBEEF || mem_err !== 1'b1 || store_cnt !== 16'd1) begin
      miscompares++;
      $display("FAIL bad_store_no_write got res=%08h err=%0d sc=%0d expected res=deadbeef err=1 sc=1",
               resultW, mem_err, store_cnt);
    end
    step(1, 1, 0, 32'h400, 32'h0, 5'd2);
    vec_cnt++;
    if (resultW !== 32'h0 || load_cnt !== 16'd2 || mem_err !== 1'b1) begin
      miscompares++;
      $display("FAIL oor_load got res=%08h lc=%0d err=%0d expected res=0 lc=2 err=1",
               resultW, load_cnt, mem_err);
    end
    // Load and store together: store wins, W must show the address, not data.
    step(1, 1, 1, 32'h10, 32'h0BADF00D, 5'd9);
    vec_cnt++;
    if (resultW !== 32'h10 || store_cnt !== 16'd2 || load_cnt !== 16'd2) begin
      miscompares++;
      $display("FAIL ld_st_both got res=%08h sc=%0d lc=%0d expected res=00000010 sc=2 lc=2",
               resultW, store_cnt, load_cnt);
    end
  endtask

  task automatic test_reset_mid_store();
    step(0, 0, 1, 32'h20, 32'h5, 5'd0);
    regwriteM  = 1'b0;
    resultsrcM = 1'b0;
    memwriteM  = 1'b1;
    aluresultM = 32'h20;
    Rd2M       = 32'h1;
    RdM        = 5'd0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    vec_cnt++;
    if ({regwriteW, RdW, resultW, mem_err, load_cnt, store_cnt} !== '0) begin
      miscompares++;
      $display("FAIL async_reset got we=%0d rd=%0d res=%08h err=%0d lc=%0d sc=%0d expected all 0",
               regwriteW, RdW, resultW, mem_err, load_cnt, store_cnt);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    step(1, 1, 0, 32'h20, 32'h0, 5'd4);
    vec_cnt++;
    if (resultW !== 32'h5 || mem_err !== 1'b0 || RdW !== 5'd4) begin
      miscompares++;
      $display("FAIL reset_mid_store got res=%08h err=%0d rd=%0d expected res=00000005 err=0 rd=4",
               resultW, mem_err, RdW);
    end
  endtask

  task automatic test_random();
    logic [31:0] alu;
    int sel;
    for (int i = 0; i < 1500; i++) begin
      sel = $urandom_range(0, 9);
      if (sel < 7)       alu = {22'd0, 3'd0, 5'($urandom), 2'b00};
      else if (sel == 7) alu = {22'd0, 8'($urandom), 2'($urandom_range(1, 3))};
      else if (sel == 8) alu = {22'($urandom_range(1, 4194303)), 10'($urandom)};
      else               alu = $urandom;
      step(1'($urandom), 1'($urandom), ($urandom_range(0, 2) == 0),
           alu, $urandom, 5'($urandom));
      vec_cnt++;
      if (regwriteW !== exp_rw || RdW !== exp_rd || (exp_known && resultW !== exp_res)) begin
        miscompares++;
        $display("FAIL random_w i=%0d got we=%0d rd=%0d res=%08h expected we=%0d rd=%0d res=%08h",
                 i, regwriteW, RdW, resultW, exp_rw, exp_rd, exp_res);
      end
      vec_cnt++;
      if (mem_err !== exp_err || int'(load_cnt) != exp_lcnt || int'(store_cnt) != exp_scnt) begin
        miscompares++;
        $display("FAIL random_dbg i=%0d got err=%0d lc=%0d sc=%0d expected err=%0d lc=%0d sc=%0d",
                 i, mem_err, load_cnt, store_cnt, exp_err, exp_lcnt, exp_scnt);
      end
    end
  endtask

  task automatic test_saturation();
    verbose = 1'b0;
    for (int i = 0; i < 65540; i++) begin
      step(1, 1, 0, 32'h10, 32'h0, 5'd1);
      if (i == 65530) begin
        vec_cnt++;
        if (int'(load_cnt) != exp_lcnt) begin
          miscompares++;
          $display("FAIL sat_approach got lc=%0d expected %0d", load_cnt, exp_lcnt);
        end
      end
    end
    verbose = 1'b1;
    vec_cnt++;
    if (load_cnt !== 16'hFFFF) begin
      miscompares++;
      $display("FAIL load_sat got lc=%04h expected ffff", load_cnt);
    end
    step(0, 0, 1, 32'h40, 32'hA5A5A5A5, 5'd0);
    step(1, 1, 0, 32'h40, 32'h0, 5'd6);
    vec_cnt++;
    if (load_cnt !== 16'hFFFF || int'(store_cnt) != exp_scnt || resultW !== 32'hA5A5A5A5) begin
      miscompares++;
      $display("FAIL post_sat got lc=%04h sc=%0d res=%08h expected lc=ffff sc=%0d res=a5a5a5a5",
               load_cnt, store_cnt, resultW, exp_scnt);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      mdl_mem[i]   = '0;
      mdl_known[i] = 1'b0;
    end
    model_reset();
    rst_n      = 1'b0;
    regwriteM  = 1'b0;
    resultsrcM = 1'b0;
    memwriteM  = 1'b0;
    aluresultM = '0;
    Rd2M       = '0;
    RdM        = '0;
    #2;
    test_reset();
    test_store_load();
    test_alu_writeback();
    test_bad_access();
    test_reset_mid_store();
    test_random();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscompares);
    $finish;
  end

endmodule
